pipe_stage_reg: RTL

//  Parametrised inter-stage pipeline register carrying {pc, instr} between CPU stages (IF/ID, ID/EX, ...).
//  - Valid/ready handshake on both sides.
//  - Optional 2-entry skid buffer, so upstream ready does not combinationally depend on downstream ready.
//  - Synchronous flush that inserts a NOP bubble.
//  - Free-running bubble counter for performance profiling.

---
 rtl/pipe_stage_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for {pc, instr} with valid/ready on both sides.
// Optional 2-entry skid buffer, flush-to-bubble and a free-running bubble counter.
module pipe_stage_reg #(
  parameter int                   PC_W      = 32,
  parameter int                   INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013),
  parameter bit                   SKID_EN   = 1'b1,
  parameter int                   CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [PC_W-1:0]    out_pc_q, out_pc_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               rdy_q, rdy_d;
  logic [CNT_W-1:0]   bubble_q;

  logic in_fire;
  logic out_fire;

  // rdy_q is low throughout reset and rises on the first edge after release,
  // so it also gates the pass-through ready of the non-skid variant.
  assign in_ready  = SKID_EN ? rdy_q : (rdy_q & (out_ready | ~out_valid_q));
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;
  assign bubble_cnt = bubble_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (flush) begin
      state_d      = EMPTY;
      out_pc_d     = '0;
      out_instr_d  = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = FULL;
            out_pc_d    = in_pc;
            out_instr_d = in_instr;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            out_pc_d    = in_pc;
            out_instr_d = in_instr;
          end else if (in_fire) begin
            // Only reachable with the skid buffer; without it in_ready tracks out_ready.
            if (SKID_EN) begin
              state_d      = SKID;
              skid_pc_d    = in_pc;
              skid_instr_d = in_instr;
            end
          end else if (out_fire) begin
            state_d     = EMPTY;
            out_pc_d    = '0;
            out_instr_d = NOP_INSTR;
          end
        end
        SKID: begin
          if (out_fire) begin
            state_d      = FULL;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
          end
        end
        default: begin
          state_d     = EMPTY;
          out_pc_d    = '0;
          out_instr_d = NOP_INSTR;
        end
      endcase
    end

    out_valid_d = (state_d != EMPTY);
    rdy_d       = SKID_EN ? (state_d != SKID) : 1'b1;
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
      // NOTE: the skid entry is reset too, so no stale payload can ever be promoted to the output.
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      rdy_q        <= rdy_d;
    end
  end

  // Counts every cycle the output carries no instruction; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
    end else if (!out_valid_q) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule
